serial_add_sequencer: RTL and testbench



---
 rtl/serial_add_sequencer_if.sv | 43 ++++
 rtl/serial_add_sequencer.sv | 113 +++++++++++
 tb/tb_serial_add_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_sequencer_if.sv
// ---------------------------------------------------------------------------
// serial_add_sequencer_if
// Bundles every non-clock signal of the serial add sequencer.
//   slave  modport : the sequencer itself
//   master modport : its environment, i.e. the operand source plus the
//                    external combinational full-adder cell
// Signals:
//   start, operand_a, operand_b, carry_in : request and operands
//   busy, done, result, carry_out         : progress and result handshake
//   fa_addend, fa_augend, fa_carry1       : drive into the full-adder cell
//   fa_sum, fa_carry2                     : answer from the full-adder cell
// ---------------------------------------------------------------------------
interface serial_add_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             carry_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             fa_addend;
  logic             fa_augend;
  logic             fa_carry1;
  logic             fa_sum;
  logic             fa_carry2;

  // The sequencer consumes the request and the adder answer and produces
  // the handshake, the result and the adder inputs.
  modport slave (
    input  start, operand_a, operand_b, carry_in, fa_sum, fa_carry2,
    output busy, done, result, carry_out, fa_addend, fa_augend, fa_carry1
  );

  // The environment is the mirror image: it issues requests and plays the
  // role of the full-adder cell.
  modport master (
    output start, operand_a, operand_b, carry_in, fa_sum, fa_carry2,
    input  busy, done, result, carry_out, fa_addend, fa_augend, fa_carry1
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// ---------------------------------------------------------------------------
// serial_add_sequencer
// Adds two WIDTH-bit operands LSB-first, one bit per clock, by time
// multiplexing a single external combinational full-adder cell.
// Ports:
//   clk  : system clock, all state changes on the rising edge
//   rst  : asynchronous active-high reset
//   bus  : serial_add_sequencer_if.slave
//          start/operand_a/operand_b/carry_in in, busy/done/result/carry_out
//          out, fa_addend/fa_augend/fa_carry1 out to the adder cell,
//          fa_sum/fa_carry2 back from it
// A request is accepted in IDLE or DONE; busy is high for WIDTH cycles,
// then done pulses for one cycle with {carry_out,result} = a + b + cin.
// ---------------------------------------------------------------------------
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  serial_add_sequencer_if.slave bus
);

  localparam int              CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] aShift_q;
  logic [WIDTH-1:0] bShift_q;
  logic [WIDTH-1:0] sumShift_q;
  logic [WIDTH-1:0] sumShift_d;
  logic [WIDTH-1:0] result_q;
  logic [CntW-1:0]  bitCnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             carryOut_q;

  // The newest sum bit enters at the MSB so that after WIDTH shifts bit i of
  // the register holds the sum of bit i. The completing edge stores this
  // next value straight into result, so result never sees a partial sum.
  assign sumShift_d = (sumShift_q >> 1) | (WIDTH'(bus.fa_sum) << (WIDTH - 1));

  // The adder cell only sees live data while running; in IDLE and DONE the
  // carry register still holds the last carry, hence the explicit gating.
  assign bus.fa_addend = (state_q == RUN) && aShift_q[0];
  assign bus.fa_augend = (state_q == RUN) && bShift_q[0];
  assign bus.fa_carry1 = (state_q == RUN) && carry_q;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carryOut_q;

  // Control FSM with registered handshake outputs. IDLE and DONE behave the
  // same towards start, which is what gives back-to-back operation when
  // start is held; the only difference is that done is high in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      aShift_q   <= '0;
      bShift_q   <= '0;
      sumShift_q <= '0;
      result_q   <= '0;
      bitCnt_q   <= '0;
      carry_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      carryOut_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            aShift_q <= bus.operand_a;
            bShift_q <= bus.operand_b;
            carry_q  <= bus.carry_in;
            bitCnt_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          aShift_q   <= aShift_q >> 1;
          bShift_q   <= bShift_q >> 1;
          sumShift_q <= sumShift_d;
          carry_q    <= bus.fa_carry2;
          bitCnt_q   <= bitCnt_q + CntW'(1);
          // This edge consumes the MSB: publish the whole result at once.
          if (bitCnt_q == LastBit) begin
            result_q   <= sumShift_d;
            carryOut_q <= bus.fa_carry2;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_serial_add_sequencer
// Drives a WIDTH=8 and a WIDTH=1 sequencer from shared stimulus (the 1-bit
// instance takes bit 0 of each operand). Each instance is paired with its own
// combinational full-adder cell. A behavioural model tracks, per instance,
// which operation is in flight and which bit it is on, and derives every
// expected output from plain arithmetic on the captured operands.
// ---------------------------------------------------------------------------
module tb_serial_add_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] aIn;
  logic [7:0] bIn;
  logic       cIn;
  logic       checkEn;

  int checks = 0;
  int errors = 0;

  serial_add_sequencer_if #(.WIDTH(8)) if8 ();
  serial_add_sequencer_if #(.WIDTH(1)) if1 ();

  assign if8.start     = start;
  assign if8.operand_a = aIn;
  assign if8.operand_b = bIn;
  assign if8.carry_in  = cIn;
  assign if1.start     = start;
  assign if1.operand_a = aIn[0];
  assign if1.operand_b = bIn[0];
  assign if1.carry_in  = cIn;

  // External full-adder cells.
  assign if8.fa_sum    = if8.fa_addend ^ if8.fa_augend ^ if8.fa_carry1;
  assign if8.fa_carry2 = (if8.fa_addend & if8.fa_augend) | (if8.fa_addend & if8.fa_carry1)
                       | (if8.fa_augend & if8.fa_carry1);
  assign if1.fa_sum    = if1.fa_addend ^ if1.fa_augend ^ if1.fa_carry1;
  assign if1.fa_carry2 = (if1.fa_addend & if1.fa_augend) | (if1.fa_addend & if1.fa_carry1)
                       | (if1.fa_augend & if1.fa_carry1);

  serial_add_sequencer #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_add_sequencer #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // DUT observations gathered per instance.
  logic       dBusy [2];
  logic       dDone [2];
  logic [8:0] dSum  [2];
  logic [2:0] dFa   [2];

  assign dBusy[0] = if8.busy;
  assign dBusy[1] = if1.busy;
  assign dDone[0] = if8.done;
  assign dDone[1] = if1.done;
  assign dSum[0]  = {if8.carry_out, if8.result};
  assign dSum[1]  = {7'd0, if1.carry_out, if1.result};
  assign dFa[0]   = {if8.fa_addend, if8.fa_augend, if8.fa_carry1};
  assign dFa[1]   = {if1.fa_addend, if1.fa_augend, if1.fa_carry1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state per instance.
  bit          mBusy [2];
  bit          mDone [2];
  int unsigned mBit  [2];
  int unsigned mA    [2];
  int unsigned mB    [2];
  int unsigned mCin  [2];
  int unsigned mSum  [2];

  function automatic int unsigned widthOf(input int ch);
    return (ch == 0) ? 8 : 1;
  endfunction

  function automatic int unsigned maskOf(input int ch);
    return (32'd1 << widthOf(ch)) - 32'd1;
  endfunction

  // What the adder cell must be fed: operand bits k and the ripple carry
  // into bit k, i.e. bit k of the sum of the operands' low k bits plus cin.
  function automatic logic [2:0] expFa(input int ch);
    int unsigned k;
    int unsigned m;
    int unsigned c;
    if (!mBusy[ch]) return 3'b000;
    k = mBit[ch];
    m = (32'd1 << k) - 32'd1;
    c = (((mA[ch] & m) + (mB[ch] & m) + mCin[ch]) >> k) & 32'd1;
    return {1'(mA[ch] >> k), 1'(mB[ch] >> k), 1'(c)};
  endfunction

  // Model: a request is taken whenever no operation is in flight; the
  // operation then spends WIDTH cycles busy and finishes with the full sum.
  always @(posedge clk or posedge rst) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (rst) begin
        mBusy[ch] <= 1'b0;
        mDone[ch] <= 1'b0;
        mBit[ch]  <= 0;
        mA[ch]    <= 0;
        mB[ch]    <= 0;
        mCin[ch]  <= 0;
        mSum[ch]  <= 0;
      end else begin
        mDone[ch] <= 1'b0;
        if (mBusy[ch]) begin
          if (mBit[ch] == widthOf(ch) - 1) begin
            mBusy[ch] <= 1'b0;
            mDone[ch] <= 1'b1;
            mSum[ch]  <= mA[ch] + mB[ch] + mCin[ch];
          end else begin
            mBit[ch] <= mBit[ch] + 1;
          end
        end else if (start) begin
          mBusy[ch] <= 1'b1;
          mBit[ch]  <= 0;
          mA[ch]    <= 32'(aIn) & maskOf(ch);
          mB[ch]    <= 32'(bIn) & maskOf(ch);
          mCin[ch]  <= 32'(cIn);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int ch, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s ch%0d: got 0x%0h, expected 0x%0h", name, ch, actual, expected);
    end
  endtask

  // Cycle-by-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      for (int ch = 0; ch < 2; ch++) begin
        checkOutput("busy", ch, int'(dBusy[ch]), int'(mBusy[ch]));
        checkOutput("done", ch, int'(dDone[ch]), int'(mDone[ch]));
        checkOutput("sum", ch, int'(dSum[ch]), int'(mSum[ch]));
        checkOutput("fa", ch, int'(dFa[ch]), int'(expFa(ch)));
      end
    end
  end

  // One-cycle start pulse; returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(posedge clk);
    #1;
    aIn   = a;
    bIn   = b;
    cIn   = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      found = dDone[0];
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: done=0, expected 1", name);
    end
  endtask

  task automatic runOp(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input int expSum);
    applyStimulus(a, b, c);
    waitDone(name);
    checkOutput(name, 0, int'(dSum[0]), expSum);
    checkOutput({name, "Model"}, 0, int'(mSum[0]), expSum);
  endtask

  initial begin
    int         busyCnt;
    int         doneCnt;
    int         doneAt;
    int         opsDone;
    logic [7:0] seq;

    start   = 1'b0;
    aIn     = '0;
    bIn     = '0;
    cIn     = 1'b0;
    rst     = 1'b0;
    checkEn = 1'b0;

    #1 rst = 1'b1;
    #20 rst = 1'b0;
    checkEn = 1'b1;

    // Reset state.
    @(negedge clk);
    checkOutput("resetBusy", 0, int'(dBusy[0]), 0);
    checkOutput("resetDone", 0, int'(dDone[0]), 0);
    checkOutput("resetSum", 0, int'(dSum[0]), 0);
    checkOutput("resetFa", 0, int'(dFa[0]), 0);

    // 3C + 5A: timing, addend sequence and result.
    applyStimulus(8'h3C, 8'h5A, 1'b0);
    busyCnt = 0;
    doneCnt = 0;
    doneAt  = -1;
    seq     = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dBusy[0] && busyCnt < 8) begin
        seq[busyCnt] = if8.fa_addend;
      end
      if (dBusy[0]) busyCnt++;
      if (dDone[0]) begin
        doneCnt++;
        doneAt = i;
      end
    end
    checkOutput("busyCycles", 0, busyCnt, 8);
    checkOutput("donePulses", 0, doneCnt, 1);
    checkOutput("doneLatency", 0, doneAt, 8);
    checkOutput("addendSeq", 0, int'(seq), 8'h3C);
    checkOutput("sum3C5A", 0, int'(dSum[0]), 9'h096);
    checkOutput("sum3C5AModel", 0, int'(mSum[0]), 9'h096);

    // Carry-out boundaries.
    runOp("sumFF01", 8'hFF, 8'h01, 1'b0, 9'h100);
    runOp("sumFF00c", 8'hFF, 8'h00, 1'b1, 9'h100);

    // Start during RUN is ignored.
    applyStimulus(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    aIn   = 8'hFF;
    bIn   = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("sum1234");
    checkOutput("sum1234", 0, int'(dSum[0]), 9'h046);
    doneCnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dDone[0] || dBusy[0]) doneCnt++;
    end
    checkOutput("singleDone", 0, doneCnt, 0);

    // Start held high: back-to-back with no idle gap.
    @(posedge clk);
    #1;
    aIn   = 8'h10;
    bIn   = 8'h20;
    cIn   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    aIn = 8'h01;
    bIn = 8'h01;
    waitDone("held1");
    checkOutput("held1", 0, int'(dSum[0]), 9'h030);
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("noGap", 0, int'(dBusy[0]), 1);
    waitDone("held2");
    checkOutput("held2", 0, int'(dSum[0]), 9'h002);

    // Asynchronous reset in the middle of bit 4.
    applyStimulus(8'hAA, 8'h55, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abortBusy", 0, int'(dBusy[0]), 0);
    checkOutput("abortDone", 0, int'(dDone[0]), 0);
    checkOutput("abortSum", 0, int'(dSum[0]), 0);
    checkOutput("abortFa", 0, int'(dFa[0]), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    runOp("sumAA55", 8'hAA, 8'h55, 1'b0, 9'h0FF);

    // Random traffic, checked cycle by cycle against the model.
    opsDone = 0;
    for (int i = 0; i < 4000 && opsDone < 200; i++) begin
      @(posedge clk);
      #1;
      aIn   = 8'($urandom);
      bIn   = 8'($urandom);
      cIn   = 1'($urandom);
      start = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (mDone[0]) opsDone++;
    end
    checkOutput("randomOps", 0, (opsDone >= 200) ? 1 : 0, 1);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
